// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register offsets, STATUS bit layout, bus widths and transmitter state encoding.
package uart_tx_mmio_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned BIT_IDX_W = 3;

    // Register offsets relative to BASE_ADDR
    localparam logic [ADDR_W-1:0] REG_DATA_OFS   = 16'h0000;
    localparam logic [ADDR_W-1:0] REG_STATUS_OFS = 16'h0001;

    // STATUS bit positions
    localparam int unsigned STAT_FULL_BIT   = 0;
    localparam int unsigned STAT_EMPTY_BIT  = 1;
    localparam int unsigned STAT_ACTIVE_BIT = 2;
    localparam int unsigned STAT_OVF_BIT    = 3;

    // STATUS register image; field order matches the bit positions above
    typedef struct packed {
        logic [3:0] rsvd;
        logic       overflow;
        logic       tx_active;
        logic       fifo_empty;
        logic       fifo_full;
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
// Ports: clk, rst (async active-low), push/wdata (enqueue), pop/rdata (dequeue,
// rdata shows the head), full, empty. A push while full is accepted only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports: clk, rst (async active-low), addr/wdata/we (CPU store bus),
// rdata (registered read data), tx (serial line, idle high).
// Window: BASE_ADDR+0 DATA (write pushes a byte), BASE_ADDR+1 STATUS
// (read {overflow, tx_active, fifo_empty, fifo_full}; write bit3=1 clears overflow).
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        tx
);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [BAUD_W-1:0]    r_baud;
    logic [BAUD_W-1:0]    w_baud_nxt;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [BIT_IDX_W-1:0] w_bit_idx_nxt;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 w_pop;

    logic                 r_overflow;
    logic [DATA_W-1:0]    r_rdata;
    status_t              w_status;

    logic                 w_sel_data;
    logic                 w_sel_stat;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_W-1:0]    w_fifo_rdata;

    // Register decode
    assign w_sel_data = (addr == BASE_ADDR + REG_DATA_OFS);
    assign w_sel_stat = (addr == BASE_ADDR + REG_STATUS_OFS);
    assign w_push     = we & w_sel_data;
    // A full FIFO still accepts a byte when the transmitter pops in the same cycle
    assign w_ovf_set  = w_push & w_fifo_full & ~w_pop;
    assign w_ovf_clr  = we & w_sel_stat & wdata[STAT_OVF_BIT];

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (wdata),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Transmitter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Next state: tx_nxt is the level of the bit being entered, so tx is a flop
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_rdata;
                    w_baud_nxt    = BAUD_LOAD;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (r_baud == '0) begin
                    w_baud_nxt    = BAUD_LOAD;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_state_nxt   = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt = BAUD_LOAD;
                    if (r_bit_idx == BIT_IDX_W'(7)) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
                        w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (r_baud == '0) begin
                    // Chain straight into the next start bit when more data waits
                    if (!w_fifo_empty) begin
                        w_pop         = 1'b1;
                        w_shift_nxt   = w_fifo_rdata;
                        w_baud_nxt    = BAUD_LOAD;
                        w_bit_idx_nxt = '0;
                        w_tx_nxt      = 1'b0;
                        w_state_nxt   = ST_START;
                    end else begin
                        w_baud_nxt  = '0;
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - BAUD_W'(1);
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // STATUS image
    always_comb begin
        w_status            = '0;
        w_status.fifo_full  = w_fifo_full;
        w_status.fifo_empty = w_fifo_empty;
        w_status.tx_active  = (r_state != ST_IDLE);
        w_status.overflow   = r_overflow;
    end

    // Sticky overflow (set wins over clear) and registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_rdata <= w_sel_stat ? DATA_W'(w_status) : '0;
        end
    end

    assign rdata = r_rdata;
    assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4). The tx line is
// logged one step after every rising edge and compared with an ideal 8N1
// waveform computed from the bytes the CPU was expected to get onto the wire.
module tb_uart_tx_mmio;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] A_DATA = BASE;
    localparam logic [15:0] A_STAT = BASE + 16'd1;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        tx;

    int          n_checks;
    int          n_fail;
    logic        logging;
    logic        log_q[$];
    logic [7:0]  exp_frames[$];

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (logging) log_q.push_back(tx);
    end

    // Ideal line level k cycles into a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / int'(CPB);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Log index 0 is the push edge; frames of exp_frames follow back to back from index 1
    function automatic logic model_tx(input int k);
        int f;
        if (k < 1) return 1'b1;
        f = (k - 1) / int'(FRAME);
        if (f >= exp_frames.size()) return 1'b1;
        return frame_bit(exp_frames[f], (k - 1) % int'(FRAME));
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        wdata = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_log();
        log_q.delete();
        exp_frames.delete();
        logging = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 8'h00; logging = 1'b0;
        wait_cycles(3);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        rst = 1'b1;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h expected 02", d); end
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic [7:0] d;
        start_log();
        exp_frames.push_back(b);
        bus_write(A_DATA, b);
        wait_cycles(FRAME + 1);
        logging = 1'b0;
        n_checks++;
        if (log_q.size() != FRAME + 2) begin
            n_fail++; $display("FAIL single_len: got %0d expected %0d", log_q.size(), FRAME + 2);
        end else begin
            for (int k = 0; k < FRAME + 2; k++) begin
                n_checks++;
                if (log_q[k] !== model_tx(k)) begin
                    n_fail++; $display("FAIL single_tx byte %h cyc %0d: got %b expected %b", b, k, log_q[k], model_tx(k));
                end
            end
        end
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL single_status: got %h expected 02", d); end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        start_log();
        exp_frames.push_back(b0);
        exp_frames.push_back(b1);
        bus_write(A_DATA, b0);
        bus_write(A_DATA, b1);
        wait_cycles(2 * FRAME);
        logging = 1'b0;
        n_checks++;
        if (log_q.size() != 2 * FRAME + 2) begin
            n_fail++; $display("FAIL b2b_len: got %0d expected %0d", log_q.size(), 2 * FRAME + 2);
        end else begin
            for (int k = 0; k < 2 * FRAME + 2; k++) begin
                n_checks++;
                if (log_q[k] !== model_tx(k)) begin
                    n_fail++; $display("FAIL b2b_tx cyc %0d: got %b expected %b", k, log_q[k], model_tx(k));
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] b;
        start_log();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            if (i < 5) exp_frames.push_back(b);
            bus_write(A_DATA, b);
        end
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h0D) begin n_fail++; $display("FAIL ovf_status: got %h expected 0D", d); end
        bus_write(A_STAT, 8'h08);
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h05) begin n_fail++; $display("FAIL ovf_clear: got %h expected 05", d); end
        bus_write(A_DATA, 8'($urandom));
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h0D) begin n_fail++; $display("FAIL ovf_reset_again: got %h expected 0D", d); end
        bus_write(A_STAT, 8'($urandom) & 8'hF7);
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h0D) begin n_fail++; $display("FAIL ovf_noclear_bit3_0: got %h expected 0D", d); end
        bus_write(A_STAT, 8'($urandom) | 8'h08);
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h05) begin n_fail++; $display("FAIL ovf_clear2: got %h expected 05", d); end
        wait_cycles(5 * FRAME + 2 - log_q.size());
        logging = 1'b0;
        n_checks++;
        if (log_q.size() != 5 * FRAME + 2) begin
            n_fail++; $display("FAIL ovf_len: got %0d expected %0d", log_q.size(), 5 * FRAME + 2);
        end else begin
            for (int k = 0; k < 5 * FRAME + 2; k++) begin
                n_checks++;
                if (log_q[k] !== model_tx(k)) begin
                    n_fail++; $display("FAIL ovf_tx cyc %0d: got %b expected %b", k, log_q[k], model_tx(k));
                end
            end
        end
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL ovf_final_status: got %h expected 02", d); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        logic [7:0] b0;
        b0 = 8'($urandom) & 8'hF7;   // data bit 3 low so the abort is visible on tx
        bus_write(A_DATA, b0);
        bus_write(A_DATA, 8'($urandom));
        bus_write(A_DATA, 8'($urandom));
        bus_read(A_STAT, d);          // addr stays on STATUS so rdata is non-zero
        n_checks++;
        if (d !== 8'h04) begin n_fail++; $display("FAIL mid_status_busy: got %h expected 04", d); end
        wait_cycles(14);              // now inside data bit 3 of the first frame
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b expected 0", tx); end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_abort_tx: got %b expected 1", tx); end
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_abort_rdata: got %h expected 00", rdata); end
        wait_cycles(2);
        rst = 1'b1;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL mid_after_release: got %h expected 02", d); end
        test_single_frame(8'($urandom));
    endtask

    task automatic test_decode();
        logic [7:0]  d;
        logic [15:0] a;
        bus_read(A_STAT, d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL dec_status: got %h expected 02", d); end
        bus_read(16'h1234, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL dec_outside: got %h expected 00", d); end
        bus_read(A_STAT, d);
        bus_read(A_DATA, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL dec_data_read: got %h expected 00", d); end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_STAT, d);
            a = 16'($urandom_range(0, 32'hFEFF));
            bus_read(a, d);
            n_checks++;
            if (d !== 8'h00) begin n_fail++; $display("FAIL dec_random %h: got %h expected 00", a, d); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_frame(8'hA5);
        for (int i = 0; i < 3; i++) test_single_frame(8'($urandom));
        test_back_to_back(8'h01, 8'h02);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_overflow();
        test_reset_midframe();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hFF00, which sets the base address of its two-register window.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal values 2..65535).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two >= 2.
REQ-004 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 addr  input  16  CPU bus address.
REQ-007 wdata  input  8  CPU write data, driven from the CPU data-out bus.
REQ-008 we  input  1  CPU write strobe; a single-cycle pulse per store.
REQ-009 rdata  output  8  read data, driven onto the CPU data-in mux.
REQ-010 tx  output  1  serial line, idle high.

Function
REQ-011 Register map: BASE_ADDR+0 is DATA (write only); BASE_ADDR+1 is STATUS (read/write).
REQ-012 STATUS read bits SHALL be: bit0 fifo_full, bit1 fifo_empty, bit2 tx_active, bit3 overflow (sticky); bits 7:4 read as 0.
REQ-013 rdata SHALL be registered, reflecting addr one clock after it is presented.
REQ-014 rdata SHALL be 8'h00 for any address outside the window and for DATA reads.
REQ-015 A cycle with we=1 and addr=BASE_ADDR SHALL push wdata into the FIFO if the FIFO is not full.
REQ-016 If the FIFO is full at such a push, wdata SHALL be dropped and overflow set to 1.
REQ-017 A cycle with we=1, addr=BASE_ADDR+1 and wdata[3]=1 SHALL clear overflow.
REQ-018 If a clear and an overflowing push occur in the same cycle, the set SHALL win.
REQ-019 A same-cycle push and pop SHALL both take effect; occupancy is unchanged, including when the FIFO is full.
REQ-020 Transmitter FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 IDLE -> START on the first cycle the FIFO is non-empty; the head byte SHALL be popped and latched into a shift register in that same cycle.
REQ-022 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-023 DATA SHALL shift out 8 bits LSB first, each held for CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
REQ-024 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-025 At the end of STOP, the FSM SHALL go directly to START (popping the next byte) if the FIFO is non-empty, otherwise to IDLE.
REQ-026 A frame SHALL therefore be exactly 10*CLKS_PER_BIT cycles, and back-to-back frames SHALL have no idle gap.
REQ-027 The baud counter SHALL load CLKS_PER_BIT-1 on entry to each bit and decrement to 0; the bit ends at count 0.
REQ-028 tx_active SHALL be 1 in every state other than IDLE.
REQ-029 tx SHALL be driven from a flop (glitch-free).
REQ-030 Writes to the window while a frame is in progress SHALL NOT disturb the bit in flight.

Reset
REQ-031 On rst=0, asynchronously: tx=1, rdata=8'h00, FIFO empty, overflow=0, FSM=IDLE, counters=0.
REQ-032 Assertion mid-frame SHALL abort the frame immediately (tx=1) and discard all FIFO contents.
REQ-033 After deassertion, the first push SHALL start a clean frame.

Structure
REQ-034 Register offsets, STATUS bit positions and FSM state encodings SHALL be defined in the shared constants include, alongside the opcode constants.
REQ-035 The FIFO SHALL be a sub-module, sync_fifo, parameterised by width (8) and depth, with push/pop/full/empty ports and the same clk/rst.
REQ-036 The FSM, baud counter and register decode SHALL reside in uart_tx_mmio.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-037 Write 8'hA5 to DATA -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; total 40 cycles.
REQ-038 Write 8'h01 then 8'h02 in consecutive stores -> two frames spanning 80 cycles with no idle cycle between the stop bit and the next start bit.
REQ-039 Hold the transmitter busy and write 6 bytes -> the first is popped immediately, 4 are queued, and the 6th is dropped; STATUS reads 8'h0D (full, active, overflow).
REQ-040 Write 8'h08 to STATUS while overflow=1 -> next STATUS read shows bit3=0; a clear coinciding with an overflowing push leaves bit3=1.
REQ-041 Assert rst at bit 3 of a frame with 2 bytes queued -> tx=1 within the same cycle, and after release STATUS reads 8'h02.
REQ-042 Read addr=16'h1234 and addr=BASE_ADDR -> rdata=8'h00 one cycle later in both cases.
